instr_encoder_loader: RTL

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/instr_encoder_loader_pkg.sv | 56 +++++
 rtl/instr_encoder_loader_fifo.sv | 63 ++++++
 rtl/instr_encoder_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: request class codes,
// the BX opcode constant, the FSM state encoding, the request record and the
// encode/legality helpers used by the loader datapath.
package instr_encoder_loader_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_BX  = 2'b11;

  // Fixed middle field of a BX instruction.
  localparam logic [23:0] BX_CONST = 24'h12FFF1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One instruction request as presented on the req_* ports.
  typedef struct packed {
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] src2;
    logic        last;
  } instr_req_t;

  // Build the 32-bit instruction word for a request.
  function automatic logic [DATA_W-1:0] encode_instr(input instr_req_t r);
    logic [DATA_W-1:0] w;
    unique case (r.cls)
      CLS_DP:  w = {r.cond, 2'b00, r.funct, r.rn, r.rd, r.src2[11:0]};
      CLS_MEM: w = {r.cond, 2'b01, r.funct, r.rn, r.rd, r.src2[11:0]};
      CLS_BR:  w = {r.cond, 2'b10, r.funct[5:4], r.src2[23:0]};
      default: w = {r.cond, BX_CONST, r.src2[3:0]};
    endcase
    return w;
  endfunction

  // Illegal: a DP compare-class op without the S bit, or a branch whose
  // funct[5] marker is clear.
  function automatic logic req_illegal(input instr_req_t r);
    logic bad;
    bad = 1'b0;
    if (r.cls == CLS_DP && r.funct[4:3] == 2'b10 && !r.funct[0]) bad = 1'b1;
    if (r.cls == CLS_BR && !r.funct[5])                          bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// instr_req_fifo: small synchronous request buffer used by the loader when
// ENCODER_FIFO_EN is defined. A push into a full FIFO is taken when a pop
// happens in the same cycle. Storage is not reset; only pointers and fill
// level are, so a reset or clear flushes the contents.
module instr_req_fifo
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       push,
  input  instr_req_t din,
  input  logic       pop,
  output instr_req_t dout,
  output logic       full,
  output logic       empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

  instr_req_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fill;
  logic              do_push;
  logic              do_pop;

  assign full    = (fill == FULL_LVL);
  assign empty   = (fill == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; clr drops every buffered entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Entry storage, written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction requests during a load session,
// encodes each into a 32-bit word and writes it to instruction memory at
// consecutive word addresses starting from base_addr.
// Build option: define ENCODER_FIFO_EN to buffer requests in a 4-entry
// instr_req_fifo so request acceptance overlaps memory writes; otherwise a
// single encode register is used and requests are taken only in ACCEPT.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_class,
  input  logic [3:0]  req_cond,
  input  logic [5:0]  req_funct,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [23:0] req_src2,
  input  logic        req_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  state_e            state_q;
  state_e            state_d;
  logic [31:0]       addr_q;
  logic [15:0]       count_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_p1;
  logic              last_p1;

  instr_req_t        in_req;
  instr_req_t        src_req;
  logic              src_vld;
  logic              consume;
  logic              legal;
  logic              session_start;
  logic              write_fire;

  // Count of written words never wraps back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_req = {req_class, req_cond, req_funct, req_rn, req_rd, req_src2, req_last};

  assign session_start = (state_q == ST_IDLE) && start;
  assign write_fire    = (state_q == ST_WRITE) && imem_ready;

`ifdef ENCODER_FIFO_EN
  instr_req_t fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

  // The encode register is free only in ACCEPT, so that is where the FIFO
  // drains; a full FIFO still takes a push in the cycle it is popped.
  assign fifo_pop  = (state_q == ST_ACCEPT) && !fifo_empty;
  assign req_ready = busy && (!fifo_full || fifo_pop);
  assign fifo_push = req_valid && req_ready;
  assign src_vld   = !fifo_empty;
  assign src_req   = fifo_dout;

  instr_req_fifo #(
    .DEPTH (4)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (session_start),
    .push    (fifo_push),
    .din     (in_req),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  // Without buffering the request is taken straight into the encode register.
  assign req_ready = (state_q == ST_ACCEPT);
  assign src_vld   = req_valid;
  assign src_req   = in_req;
`endif

  assign consume = (state_q == ST_ACCEPT) && src_vld;
  assign legal   = !req_illegal(src_req);

  // State register; reset forces IDLE at once, which drops imem_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    imem_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        busy = 1'b1;
        if (consume) begin
          if (legal)             state_d = ST_WRITE;
          else if (src_req.last) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        if (imem_ready) state_d = last_p1 ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session bookkeeping: write address, written-word count and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (session_start) begin
        addr_q  <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (consume && !legal) err_q <= 1'b1;
      if (write_fire) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= sat_inc16(count_q);
      end
    end
  end

  // ---- stage p1: registered encode of the consumed request ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_p1 <= '0;
      last_p1  <= 1'b0;
    end else if (consume && legal) begin
      wdata_p1 <= encode_instr(src_req);
      last_p1  <= src_req.last;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_p1;
  assign err        = err_q;
  assign count      = count_q;

endmodule
